// File: rtl/instr_register_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_pkg
// Description : Shared types for the instruction-register execution block:
//               opcode encoding, operand/result/address types and the stored
//               instruction word layout.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_register_pkg;

    // Opcode encoding; the values 8..15 are undefined and evaluate to zero.
    typedef enum logic [3:0] {
        ZERO  = 4'd0,
        PASSA = 4'd1,
        PASSB = 4'd2,
        ADD   = 4'd3,
        SUB   = 4'd4,
        MULT  = 4'd5,
        DIV   = 4'd6,
        MOD   = 4'd7
    } opcode_t;

    typedef logic signed [31:0] operand_t;
    typedef logic signed [63:0] result_t;
    typedef logic        [4:0]  address_t;

    // Stored entry: 4 + 32 + 32 + 64 = 132 bits, opcode in the MSBs.
    typedef struct packed {
        opcode_t  opc;
        operand_t op_a;
        operand_t op_b;
        result_t  rez;
    } instruction_t;

    // Register file depth implied by the address width.
    localparam int c_ADDR_DEPTH = 2 ** $bits(address_t);

endpackage : instr_register_pkg
`default_nettype wire

// File: rtl/instr_alu.sv
`default_nettype none
// ============================================================================
// Module      : instr_alu
// Description : Combinational ALU evaluated at write time. Operands are
//               sign-extended to 64 bits before any arithmetic, so ADD/SUB
//               never wrap at 32 bits.
//               Build option IR_MULDIV_EN: when defined, MULT/DIV/MOD are
//               computed; when undefined they return 0 and no multiplier or
//               divider is built.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_alu
    import instr_register_pkg::*;
(
    input  opcode_t  i_opcode,
    input  operand_t i_a,
    input  operand_t i_b,
    output result_t  o_result
);

    result_t w_a64;
    result_t w_b64;
    result_t w_result;

    // Signed operands sign-extend on assignment to the 64-bit result type.
    assign w_a64 = i_a;
    assign w_b64 = i_b;

    // Opcode decode; undefined encodings fall through to zero.
    always_comb begin
        w_result = '0;
        case (i_opcode)
            ZERO:  w_result = '0;
            PASSA: w_result = w_a64;
            PASSB: w_result = w_b64;
            ADD:   w_result = w_a64 + w_b64;
            SUB:   w_result = w_a64 - w_b64;
`ifdef IR_MULDIV_EN
            // 64-bit operands hold the full 32x32 signed product exactly.
            MULT:  w_result = w_a64 * w_b64;
            // 64-bit division avoids the -2^31 / -1 overflow; SV division
            // truncates toward zero and % follows the dividend's sign.
            DIV:   w_result = (i_b == '0) ? '0 : (w_a64 / w_b64);
            MOD:   w_result = (i_b == '0) ? '0 : (w_a64 % w_b64);
`else
            MULT, DIV, MOD: w_result = '0;
`endif
            default: w_result = '0;
        endcase
    end

    assign o_result = w_result;

endmodule : instr_alu
`default_nettype wire

// File: rtl/instr_register_exec.sv
`default_nettype none
// ============================================================================
// Module      : instr_register_exec
// Description : Instruction register file. Writes store opcode, operands and
//               the ALU result computed at write time; a registered read port
//               returns the addressed entry one cycle after sampling the read
//               pointer. Reads in the same cycle as a write to the same
//               address return the old contents.
//               Build option IR_MULDIV_EN (inside instr_alu) enables
//               MULT/DIV/MOD.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_register_exec
    import instr_register_pkg::*;
#(
    // Must equal 2**$bits(address_t) so every address maps to one entry.
    parameter int NUM_ENTRIES = 32
)(
    input  logic         clk,
    input  logic         reset,
    input  logic         load_en,
    input  opcode_t      opcode,
    input  operand_t     operand_a,
    input  operand_t     operand_b,
    input  address_t     write_pointer,
    input  address_t     read_pointer,
    output instruction_t instruction_word,
    output result_t      result,
    output logic         rd_valid
);

    instruction_t               r_entries [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0]     r_valid;
    instruction_t               r_rd_word;
    result_t                    r_rd_result;
    logic                       r_rd_valid;

    result_t                    w_alu_result;
    instruction_t               w_new_entry;

    instr_alu u_alu (
        .i_opcode (opcode),
        .i_a      (operand_a),
        .i_b      (operand_b),
        .o_result (w_alu_result)
    );

    assign w_new_entry = '{opc: opcode, op_a: operand_a, op_b: operand_b, rez: w_alu_result};

    // Write port: store the full entry and mark it valid; reset wins over a
    // simultaneous write so that write is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_entries[i] <= '0;
            end
            r_valid <= '0;
        end else if (load_en) begin
            r_entries[write_pointer] <= w_new_entry;
            r_valid[write_pointer]   <= 1'b1;
        end
    end

    // Read port: registered every cycle; sees pre-write contents on a
    // same-address collision because the array updates non-blocking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_word   <= '0;
            r_rd_result <= '0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_rd_word   <= r_entries[read_pointer];
            r_rd_result <= r_entries[read_pointer].rez;
            r_rd_valid  <= r_valid[read_pointer];
        end
    end

    assign instruction_word = r_rd_word;
    assign result           = r_rd_result;
    assign rd_valid         = r_rd_valid;

endmodule : instr_register_exec
`default_nettype wire

// File: doc/instr_register_exec.md
Name: instr_register_exec

Overview:
- Design-side responder for the instruction-register testbench interface.
- Stores opcode/operand writes into a NUM_ENTRIES-deep register file.
- Computes each entry's result at write time.
- Returns the stored instruction word and result on a registered read port.
- Driven by the test program through the clocking block; outputs are sampled back by the same interface.

Parameters:
- NUM_ENTRIES, 32, depth of the register file; must equal 2**$bits(address_t).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- load_en  input  1  write strobe; entry at write_pointer is written on posedge when high.
- opcode  input  opcode_t (4)  operation to store.
- operand_a  input  operand_t (32, signed)  first operand.
- operand_b  input  operand_t (32, signed)  second operand.
- write_pointer  input  address_t (5)  write address.
- read_pointer  input  address_t (5)  read address.
- instruction_word  output  instruction_t (132)  registered {opc, op_a, op_b, rez} of the entry addressed by read_pointer.
- result  output  result_t (64, signed)  registered copy of instruction_word.rez.
- rd_valid  output  1  registered; high when the read entry has been written since reset.

Behaviour:
- Reset (async assert, sync release):
  - All entries cleared to {ZERO, 0, 0, 0}.
  - All entry-valid bits cleared.
  - instruction_word = 0, result = 0, rd_valid = 0.
  - Reset takes effect mid-operation: a write in the same cycle is lost.
- Write path:
  - When load_en = 1 on posedge, entry[write_pointer] <= {opcode, operand_a, operand_b, alu(opcode, a, b)}.
  - valid[write_pointer] <= 1.
  - Zero-latency compute: result is stored together with the operands.
- Read path:
  - Every posedge, instruction_word <= entry[read_pointer], result <= entry[read_pointer].rez, rd_valid <= valid[read_pointer].
  - Latency is 1 cycle from read_pointer being sampled.
- Simultaneous write and read to the same address:
  - Read-before-write; the read returns the old contents.
  - The new value is visible on the following read.
- Pointers are not incremented internally; wrap-around is the driver's responsibility.
- Address 31 is a normal entry.
- Rewriting an entry overwrites it; there is no full/empty state.
- ALU rules, all results sign-extended to 64 bits:
  - ZERO = 0; PASSA = a; PASSB = b.
  - ADD = a+b; SUB = a-b, computed at 64 bits with no overflow wrap.
  - MULT = full 64-bit signed product.
  - DIV truncates toward zero; MOD takes the sign of the dividend.
  - DIV or MOD with b = 0 gives 0.
  - Undefined opcode encodings give 0.

Optional Feature:
- Macro IR_MULDIV_EN.
- Defined: MULT, DIV and MOD are computed as above.
- Undefined:
  - MULT, DIV and MOD store result 0; no multiplier or divider is inferred.
  - Their opcode and operands are still stored, and the valid bit is still set.

Decomposition:
- instr_register_pkg holds:
  - opcode_t: enum logic [3:0] {ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD}.
  - operand_t: logic signed [31:0].
  - result_t: logic signed [63:0].
  - address_t: logic [4:0].
  - instruction_t: packed struct {opc, op_a, op_b, rez}.
- Sub-module instr_alu: combinational; inputs opcode, a, b; output result_t.
  - The IR_MULDIV_EN guard lives inside instr_alu.

Test Plan:
- Reset, then read addresses 0..31 -> instruction_word = 0, result = 0, rd_valid = 0 on every read.
- Write ADD a=7 b=-3 at address 2, then read address 2 -> next cycle result = 4, opc = ADD, rd_valid = 1.
- Write SUB a=-2147483648 b=1 at address 5 -> result = -2147483649, no 32-bit wrap.
- Write DIV a=-7 b=2 at address 0 -> result = -3; MOD a=-7 b=2 -> -1; DIV a=5 b=0 -> 0.
  - With IR_MULDIV_EN undefined, MULT a=3 b=4 -> 0.
- Same-cycle write of PASSA a=9 and read at address 10, where address 10 already holds PASSB b=1:
  - First read returns result = 1.
  - Next read returns result = 9.
- Write 10 entries, assert reset mid-sequence while load_en = 1, then read them back -> all zero, rd_valid = 0; the write in the reset cycle is not stored.
